prog_delay_ctrl: RTL and testbench

//  Runtime-programmable delay line controller for the ox general_lib streaming path.

---
 rtl/prog_delay_ctrl_if.sv | 27 ++
 rtl/prog_delay_ctrl.sv | 130 +++++++++++++
 tb/tb_prog_delay_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/prog_delay_ctrl_if.sv
// Stream and configuration signals of the programmable delay line.
// master = the block feeding samples and requests, slave = the delay controller.
interface prog_delay_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEL_W = 7
);
  logic             ce;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [DEL_W-1:0] cfg_delay;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;
  logic [DEL_W-1:0] cur_delay;
  logic             busy;

  modport master (
    output ce, din, cfg_delay, cfg_valid,
    input  dout, dout_valid, cfg_ready, cfg_err, cur_delay, busy
  );

  modport slave (
    input  ce, din, cfg_delay, cfg_valid,
    output dout, dout_valid, cfg_ready, cfg_err, cur_delay, busy
  );
endinterface

// File: rtl/prog_delay_ctrl.sv
// Runtime-programmable delay line: circular buffer of MAX_DELAY samples,
// reconfigured through a valid/ready request. Output is masked after each
// reconfiguration until a full window at the new length has been captured.
module prog_delay_ctrl #(
  parameter int    WIDTH         = 8,
  parameter int    MAX_DELAY     = 64,
  parameter int    DEFAULT_DELAY = 4,
  parameter string ALLOW_SRL     = "YES"
) (
  input  logic             clk,
  input  logic             rst_n,
  prog_delay_ctrl_if.slave bus
);
  localparam int DEL_W = $clog2(MAX_DELAY + 1);
  localparam int PTR_W = $clog2(MAX_DELAY);
  localparam logic [DEL_W-1:0] MAX_D = DEL_W'(MAX_DELAY);
  localparam logic [DEL_W-1:0] DEF_D = DEL_W'(DEFAULT_DELAY);

  typedef enum logic [1:0] {S_FILL, S_RUN, S_APPLY} state_e;

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEL_W-1:0] cur_delay_q;
  logic [DEL_W-1:0] pend_q;
  logic [DEL_W-1:0] fill_cnt_q;
  logic [DEL_W-1:0] fill_cnt_d;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             cfg_ready_q;
  logic             cfg_err_q;
  logic             busy_q;
  logic             accept;
  logic             in_range;

  assign accept     = bus.cfg_valid & cfg_ready_q;
  assign in_range   = (bus.cfg_delay != '0) && (bus.cfg_delay <= MAX_D);
  assign fill_cnt_d = fill_cnt_q + DEL_W'(1);

  // Before this edge's write, slot wr_ptr-k holds the sample from k ce edges
  // ago, so reading D-1 back gives a D-stage shift register output.
  assign rd_ptr = wr_ptr_q - PTR_W'(cur_delay_q - DEL_W'(1));
  // D=1 has no buffer stage: take the incoming sample directly.
  assign data_d = (cur_delay_q == DEL_W'(1)) ? bus.din : rd_data;

  // Sample storage; contents are never reset, dout_valid masks stale entries.
  if (ALLOW_SRL == "NO") begin : g_ff
    (* ram_style = "registers", shreg_extract = "no" *)
    logic [WIDTH-1:0] mem [MAX_DELAY];
    // Write every ce-qualified sample at the write pointer.
    always_ff @(posedge clk) begin
      if (bus.ce) mem[wr_ptr_q] <= bus.din;
    end
    assign rd_data = mem[rd_ptr];
  end else begin : g_mem
    logic [WIDTH-1:0] mem [MAX_DELAY];
    // Write every ce-qualified sample at the write pointer.
    always_ff @(posedge clk) begin
      if (bus.ce) mem[wr_ptr_q] <= bus.din;
    end
    assign rd_data = mem[rd_ptr];
  end

  // Write pointer advances on every ce edge in all states; wraps as MAX_DELAY is 2^n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      wr_ptr_q <= '0;
    else if (bus.ce) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
  end

  // Output register follows the delay in force at the edge, only on ce edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      data_q <= '0;
    else if (bus.ce) data_q <= data_d;
  end

  // Reconfiguration FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FILL;
      cur_delay_q <= DEF_D;
      pend_q      <= DEF_D;
      fill_cnt_q  <= '0;
      valid_q     <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        S_APPLY: begin
          cur_delay_q <= pend_q;
          fill_cnt_q  <= '0;
          valid_q     <= 1'b0;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b1;
          state_q     <= S_FILL;
        end
        default: begin
          if (accept && in_range) begin
            // A new length takes priority over completing the current fill.
            pend_q      <= bus.cfg_delay;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_APPLY;
          end else begin
            // Out-of-range requests are consumed and flagged, nothing else moves.
            cfg_err_q <= accept;
            if (state_q == S_FILL && bus.ce) begin
              fill_cnt_q <= fill_cnt_d;
              if (fill_cnt_d == cur_delay_q) begin
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_RUN;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.dout       = valid_q ? data_q : '0;
  assign bus.dout_valid = valid_q;
  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.cur_delay  = cur_delay_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_prog_delay_ctrl.sv
// Randomized bench for prog_delay_ctrl with a sample-history reference model.
module tb_prog_delay_ctrl;
  localparam int W = 8;
  localparam int MAXD = 64;
  localparam int DEFD = 4;
  localparam int DW = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  prog_delay_ctrl_if #(.WIDTH(W), .DEL_W(DW)) bus ();

  prog_delay_ctrl #(.WIDTH(W), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD), .ALLOW_SRL("YES")) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: every captured sample is kept; when valid the output is
  // simply the sample cur ce-edges back in that history.
  logic [7:0] hist[$];
  int base, cur, pend;
  bit apply, mvalid, merr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      base = 0; cur = DEFD; pend = DEFD;
      apply = 0; mvalid = 0; merr = 0;
    end else begin
      bit acc, ok;
      acc = bus.cfg_valid && !apply;
      ok  = (bus.cfg_delay >= 1) && (bus.cfg_delay <= MAXD);
      if (bus.ce) hist.push_back(bus.din);
      if (apply) begin
        cur = pend; apply = 0; mvalid = 0; base = hist.size();
      end else if (acc && ok) begin
        pend = int'(bus.cfg_delay); apply = 1;
      end else begin
        mvalid = (hist.size() - base) >= cur;
      end
      merr = acc && !ok;
    end
  end

  // Compare every output against the model each cycle, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] ed;
    ed = mvalid ? hist[hist.size() - cur] : 8'd0;
    chk("dout", 32'(bus.dout), 32'(ed));
    chk("dout_valid", 32'(bus.dout_valid), 32'(mvalid));
    chk("cfg_ready", 32'(bus.cfg_ready), 32'(!apply));
    chk("cfg_err", 32'(bus.cfg_err), 32'(merr));
    chk("cur_delay", 32'(bus.cur_delay), 32'(cur));
    chk("busy", 32'(bus.busy), 32'(apply || !mvalid));
  end

  task automatic step(input bit c, input logic [7:0] d, input bit cv, input logic [DW-1:0] cd);
    bus.ce = c; bus.din = d; bus.cfg_valid = cv; bus.cfg_delay = cd;
    @(negedge clk);
  endtask

  logic [7:0] dn;
  logic [7:0] first;

  initial begin
    bus.ce = 0; bus.din = 0; bus.cfg_valid = 0; bus.cfg_delay = 0;
    @(negedge clk);
    // reset state
    chk("rst dout", 32'(bus.dout), 0);
    chk("rst valid", 32'(bus.dout_valid), 0);
    chk("rst cur_delay", 32'(bus.cur_delay), DEFD);
    chk("rst ready", 32'(bus.cfg_ready), 1);
    chk("rst busy", 32'(bus.busy), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // default delay fill: valid on 4th edge with the first sample
    step(1, 8'd1, 0, 0); step(1, 8'd2, 0, 0); step(1, 8'd3, 0, 0);
    chk("t1 valid before", 32'(bus.dout_valid), 0);
    step(1, 8'd4, 0, 0);
    chk("t1 valid", 32'(bus.dout_valid), 1);
    chk("t1 dout", 32'(bus.dout), 1);
    chk("t1 busy", 32'(bus.busy), 0);
    step(1, 8'd5, 0, 0);
    chk("t1 dout next", 32'(bus.dout), 2);
    dn = 8'd6;

    // gated ce
    for (int i = 0; i < 16; i++) begin
      step(i % 2 == 0, dn, 0, 0);
      if (i % 2 == 0) dn++;
    end

    // reconfigure 4 -> 10
    step(1, dn, 1, 7'd10); dn++;
    chk("t3 ready apply", 32'(bus.cfg_ready), 0);
    chk("t3 cur old", 32'(bus.cur_delay), 4);
    step(1, dn, 0, 0); dn++;
    chk("t3 ready back", 32'(bus.cfg_ready), 1);
    chk("t3 valid off", 32'(bus.dout_valid), 0);
    chk("t3 cur new", 32'(bus.cur_delay), 10);
    first = dn;
    for (int k = 1; k <= 10; k++) begin
      step(1, dn, 0, 0); dn++;
      if (k == 9) chk("t3 valid early", 32'(bus.dout_valid), 0);
    end
    chk("t3 valid", 32'(bus.dout_valid), 1);
    chk("t3 dout first", 32'(bus.dout), 32'(first));

    // out-of-range requests
    step(1, dn, 1, 7'd0); dn++;
    chk("t4 err 0", 32'(bus.cfg_err), 1);
    chk("t4 valid kept", 32'(bus.dout_valid), 1);
    step(1, dn, 1, 7'(MAXD + 1)); dn++;
    chk("t4 err max+1", 32'(bus.cfg_err), 1);
    chk("t4 cur kept", 32'(bus.cur_delay), 10);
    step(1, dn, 0, 0); dn++;
    chk("t4 err clear", 32'(bus.cfg_err), 0);

    // D=1 bypass
    step(1, dn, 1, 7'd1); dn++;
    step(1, dn, 0, 0); dn++;
    step(1, dn, 0, 0);
    chk("t5 d1 valid", 32'(bus.dout_valid), 1);
    chk("t5 d1 dout", 32'(bus.dout), 32'(dn));
    dn++;
    for (int i = 0; i < 3 * MAXD; i++) begin step(1, dn, 0, 0); dn++; end

    // D=MAX_DELAY across several pointer wraps
    step(1, dn, 1, 7'(MAXD)); dn++;
    step(1, dn, 0, 0); dn++;
    first = dn;
    for (int i = 0; i < MAXD - 1; i++) begin step(1, dn, 0, 0); dn++; end
    chk("t5 dmax valid early", 32'(bus.dout_valid), 0);
    step(1, dn, 0, 0); dn++;
    chk("t5 dmax valid", 32'(bus.dout_valid), 1);
    chk("t5 dmax dout", 32'(bus.dout), 32'(first));
    for (int i = 0; i < 3 * MAXD; i++) begin step(1, dn, 0, 0); dn++; end

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit c, cv;
      logic [DW-1:0] cd;
      c  = ($urandom_range(0, 9) < 7);
      cv = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 9))
        0:       cd = 7'd0;
        1:       cd = 7'($urandom_range(MAXD + 1, 127));
        2:       cd = 7'($urandom_range(17, MAXD));
        default: cd = 7'($urandom_range(1, 16));
      endcase
      step(c, 8'($urandom), cv, cd);
    end

    // async reset mid-fill after a cfg to 20
    step(1, dn, 1, 7'd20); dn++;
    step(1, dn, 0, 0); dn++;
    chk("t6 cur 20", 32'(bus.cur_delay), 20);
    for (int i = 0; i < 5; i++) begin step(1, dn, 0, 0); dn++; end
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async dout", 32'(bus.dout), 0);
    chk("t6 async valid", 32'(bus.dout_valid), 0);
    chk("t6 async cur", 32'(bus.cur_delay), DEFD);
    chk("t6 async busy", 32'(bus.busy), 1);
    chk("t6 async ready", 32'(bus.cfg_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'd1, 0, 0); step(1, 8'd2, 0, 0); step(1, 8'd3, 0, 0);
    chk("t6 refill early", 32'(bus.dout_valid), 0);
    step(1, 8'd4, 0, 0);
    chk("t6 refill valid", 32'(bus.dout_valid), 1);
    chk("t6 refill dout", 32'(bus.dout), 1);
    for (int i = 5; i < 12; i++) step(1, 8'(i), 0, 0);

    // async reset while running with a live output
    #2 rst_n = 1'b0;
    #1;
    chk("t6 run rst dout", 32'(bus.dout), 0);
    chk("t6 run rst valid", 32'(bus.dout_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1, 8'($urandom), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
